ecc_serial_host: RTL
====================

// Module: ecc_serial_host
// PURPOSE
//  Host-side end of the ECC wrapper serial link. Takes parallel operands and serializes them
//  MSB-first onto the wrapper input pins, as two jobs: mode + P/a/prime, and Pb.
//  Deserializes the wrapper's Pa/Pab bit-streams back into parallel words.
//  Sits between the system bus/testbench and the ECC wrapper.
// PARAMETERS
//  MAX_BITS  256  widest operand; words are right-justified, unused MSBs are zero
//  CNT_W     8    bit-counter width, must satisfy 2**CNT_W >= MAX_BITS
// PORTS
//  clk            in   1         single clock
//  rst            in   1         synchronous reset, active-low
//  s_pa_valid     in   1         P/a job request
//  s_pa_ready     out  1         P/a job accepted when valid&ready
//  s_mode         in   2         0=32b, 1=64b, 2=128b, 3=256b
//  s_P,s_ax,s_ay,s_prime in MAX_BITS  scalar, point a (x,y), field prime
//  s_pb_valid     in   1         Pb job request
//  s_pb_ready     out  1         Pb job accepted when valid&ready
//  s_pbx,s_pby    in   MAX_BITS  point Pb (x,y)
//  o_p_a_valid    out  1         1-cycle start pulse for the P/a job (to wrapper)
//  o_pb_valid     out  1         1-cycle start pulse for the Pb job (to wrapper)
//  o_mode         out  1         serial mode bit
//  o_P,o_ax,o_ay,o_prime out 1   serial P/a/prime bits
//  o_Pbx,o_Pby    out  1         serial Pb bits
//  i_Pa_valid,i_Pab_valid in 1   wrapper output frame valids
//  i_Pax,i_Pay,i_Pabx,i_Paby in 1  wrapper serial result bits
//  m_pa_valid     out  1         1-cycle pulse: m_pa_x/y hold a complete Pa
//  m_pa_x,m_pa_y  out  MAX_BITS  Pa result; holds value until the next Pa completes
//  m_pab_valid    out  1         1-cycle pulse: m_pab_x/y hold a complete Pab
//  m_pab_x,m_pab_y out MAX_BITS  Pab result; holds value until the next Pab completes
//  m_err          out  1         1-cycle pulse: receive frame ended early
// BEHAVIOUR
//  Reset (rst=0 at clk edge)
//   - all outputs 0; s_*_ready 0; TX FSM -> TX_IDLE; RX FSM -> RX_IDLE.
//   - Mid-frame reset drops the frame; no m_* pulse is produced.
//  Length and order
//   - N = 32/64/128/256 from the mode of the last accepted P/a job (reset mode = 0, so N = 32).
//   - Data bits are sent MSB-first: bit N-1 first, bit 0 last. Mode is sent as 2 bits, MSB first.
//  TX FSM: TX_IDLE -> TX_MODE -> TX_PA -> TX_GAP -> TX_IDLE, or TX_IDLE -> TX_PB -> TX_GAP -> TX_IDLE.
//   - TX_IDLE
//     - s_pa_ready = s_pb_ready = !rx_busy & !i_Pa_valid & !i_Pab_valid.
//     - P/a wins when both request; the losing ready is forced to 0 that cycle.
//     - On accept, operands are latched into shift regs and the start pulse is driven the same cycle.
//   - P/a job timing: pulse at cycle T; TX_MODE drives mode bits at T+1, T+2;
//     TX_PA drives bit N-1..0 of P/ax/ay/prime at T+3..T+N+2.
//   - Pb job timing: pulse at T; TX_PB drives Pbx/Pby bits N-1..0 at T+1..T+N.
//   - TX_GAP: one idle cycle with all o_* = 0, then return to TX_IDLE. Idle data pins are driven 0.
//  RX FSM: RX_IDLE -> RX_PA or RX_PAB -> RX_IDLE.
//   - Entry: on i_Pa_valid (or i_Pab_valid) high in RX_IDLE, the first bit is the MSB and is sampled that cycle.
//   - Capture: shifts in on each valid cycle; rx_busy is high from the first bit on.
//   - Completion: after N bits, the word is zero-extended to MAX_BITS and m_*_valid pulses the next cycle.
//   - Early drop: if valid drops before N bits, m_err pulses, the partial word is discarded,
//     and m_* keeps its old value.
//   - Both frame valids high in RX_IDLE: Pab wins; Pa is ignored and m_err pulses.
//  Mode change only takes effect on accept; a mode changed mid-frame does not alter N in flight.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles -> all outputs 0, s_pa_ready 0 on the first cycle after release, then 1.
//  2 P/a job, mode=0, P=32'h8000_0001 -> o_p_a_valid at T; o_mode 0,0 at T+1..T+2;
//    o_P=1 at T+3, 0 for T+4..T+33, 1 at T+34; s_pa_ready=0 until T+36.
//  3 Simultaneous s_pa_valid and s_pb_valid -> P/a sent first; Pb pulse at P/a end + 2 cycles.
//  4 Mode=3, wrapper drives i_Pa_valid for 256 cycles with bits of 0xA5..A5 -> m_pa_x == 0xA5..A5
//    and m_pa_valid pulses once, 1 cycle after the last bit.
//  5 Mode=1, i_Pab_valid drops after 40 of 64 bits -> m_err pulse; m_pab_x unchanged; rx_busy cleared.
//  6 rst=0 during TX_PA bit 10 -> o_* = 0 next cycle, FSM idle; a new job transmits correctly.

Source files
------------

// File: rtl/ecc_serial_host.sv
// ecc_serial_host: host end of the ECC wrapper serial link.
// Serializes P/a and Pb jobs MSB-first onto the wrapper pins and deserializes Pa/Pab frames.
module ecc_serial_host #(
  parameter int MAX_BITS = 256,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_pa_valid,
  output logic                s_pa_ready,
  input  logic [1:0]          s_mode,
  input  logic [MAX_BITS-1:0] s_P,
  input  logic [MAX_BITS-1:0] s_ax,
  input  logic [MAX_BITS-1:0] s_ay,
  input  logic [MAX_BITS-1:0] s_prime,
  input  logic                s_pb_valid,
  output logic                s_pb_ready,
  input  logic [MAX_BITS-1:0] s_pbx,
  input  logic [MAX_BITS-1:0] s_pby,
  output logic                o_p_a_valid,
  output logic                o_pb_valid,
  output logic                o_mode,
  output logic                o_P,
  output logic                o_ax,
  output logic                o_ay,
  output logic                o_prime,
  output logic                o_Pbx,
  output logic                o_Pby,
  input  logic                i_Pa_valid,
  input  logic                i_Pab_valid,
  input  logic                i_Pax,
  input  logic                i_Pay,
  input  logic                i_Pabx,
  input  logic                i_Paby,
  output logic                m_pa_valid,
  output logic [MAX_BITS-1:0] m_pa_x,
  output logic [MAX_BITS-1:0] m_pa_y,
  output logic                m_pab_valid,
  output logic [MAX_BITS-1:0] m_pab_x,
  output logic [MAX_BITS-1:0] m_pab_y,
  output logic                m_err
);

  typedef enum logic [2:0] {TX_IDLE, TX_MODE, TX_PA, TX_PB, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_PA, RX_PAB} rx_state_t;

  function automatic int frame_bits(input logic [1:0] m);
    return 32 << m;
  endfunction

  function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] m);
    return CNT_W'(frame_bits(m) - 1);
  endfunction

  // Left-justify the N-bit word so the serial bit is always the register MSB.
  function automatic logic [MAX_BITS-1:0] msb_align(input logic [MAX_BITS-1:0] w,
                                                    input logic [1:0] m);
    return w << (MAX_BITS - frame_bits(m));
  endfunction

  tx_state_t           tx_state_q, tx_state_d;
  rx_state_t           rx_state_q, rx_state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]    rx_rem_q, rx_rem_d;
  logic                init_q, init_d;
  logic [MAX_BITS-1:0] sh_p_q, sh_p_d, sh_ax_q, sh_ax_d, sh_ay_q, sh_ay_d;
  logic [MAX_BITS-1:0] sh_prime_q, sh_prime_d, sh_pbx_q, sh_pbx_d, sh_pby_q, sh_pby_d;
  logic [MAX_BITS-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic                m_pa_valid_q, m_pa_valid_d, m_pab_valid_q, m_pab_valid_d;
  logic                m_err_q, m_err_d;
  logic [MAX_BITS-1:0] m_pa_x_q, m_pa_x_d, m_pa_y_q, m_pa_y_d;
  logic [MAX_BITS-1:0] m_pab_x_q, m_pab_x_d, m_pab_y_q, m_pab_y_d;
  logic                rx_busy, link_free;
  logic                rx_vld, rx_bx, rx_by;

  assign rx_busy   = (rx_state_q != RX_IDLE);
  // init_q keeps the host from accepting work in the first cycle after reset release.
  assign link_free = init_q & ~rx_busy & ~i_Pa_valid & ~i_Pab_valid;

  always_comb begin
    tx_state_d  = tx_state_q;
    mode_d      = mode_q;
    tx_cnt_d    = tx_cnt_q;
    init_d      = 1'b1;
    sh_p_d      = sh_p_q;
    sh_ax_d     = sh_ax_q;
    sh_ay_d     = sh_ay_q;
    sh_prime_d  = sh_prime_q;
    sh_pbx_d    = sh_pbx_q;
    sh_pby_d    = sh_pby_q;
    s_pa_ready  = 1'b0;
    s_pb_ready  = 1'b0;
    o_p_a_valid = 1'b0;
    o_pb_valid  = 1'b0;
    o_mode      = 1'b0;
    o_P         = 1'b0;
    o_ax        = 1'b0;
    o_ay        = 1'b0;
    o_prime     = 1'b0;
    o_Pbx       = 1'b0;
    o_Pby       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        s_pa_ready = link_free;
        s_pb_ready = link_free & ~s_pa_valid;
        if (s_pa_valid && link_free) begin
          o_p_a_valid = 1'b1;
          mode_d      = s_mode;
          tx_cnt_d    = CNT_W'(1);
          sh_p_d      = msb_align(s_P, s_mode);
          sh_ax_d     = msb_align(s_ax, s_mode);
          sh_ay_d     = msb_align(s_ay, s_mode);
          sh_prime_d  = msb_align(s_prime, s_mode);
          tx_state_d  = TX_MODE;
        end else if (s_pb_valid && link_free) begin
          o_pb_valid = 1'b1;
          tx_cnt_d   = last_idx(mode_q);
          sh_pbx_d   = msb_align(s_pbx, mode_q);
          sh_pby_d   = msb_align(s_pby, mode_q);
          tx_state_d = TX_PB;
        end
      end
      TX_MODE: begin
        o_mode = (tx_cnt_q != '0) ? mode_q[1] : mode_q[0];
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = last_idx(mode_q);
          tx_state_d = TX_PA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_PA: begin
        o_P        = sh_p_q[MAX_BITS-1];
        o_ax       = sh_ax_q[MAX_BITS-1];
        o_ay       = sh_ay_q[MAX_BITS-1];
        o_prime    = sh_prime_q[MAX_BITS-1];
        sh_p_d     = {sh_p_q[MAX_BITS-2:0], 1'b0};
        sh_ax_d    = {sh_ax_q[MAX_BITS-2:0], 1'b0};
        sh_ay_d    = {sh_ay_q[MAX_BITS-2:0], 1'b0};
        sh_prime_d = {sh_prime_q[MAX_BITS-2:0], 1'b0};
        if (tx_cnt_q == '0) tx_state_d = TX_GAP;
        else                tx_cnt_d   = tx_cnt_q - CNT_W'(1);
      end
      TX_PB: begin
        o_Pbx    = sh_pbx_q[MAX_BITS-1];
        o_Pby    = sh_pby_q[MAX_BITS-1];
        sh_pbx_d = {sh_pbx_q[MAX_BITS-2:0], 1'b0};
        sh_pby_d = {sh_pby_q[MAX_BITS-2:0], 1'b0};
        if (tx_cnt_q == '0) tx_state_d = TX_GAP;
        else                tx_cnt_d   = tx_cnt_q - CNT_W'(1);
      end
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_rem_d      = rx_rem_q;
    rx_x_d        = rx_x_q;
    rx_y_d        = rx_y_q;
    m_pa_valid_d  = 1'b0;
    m_pab_valid_d = 1'b0;
    m_err_d       = 1'b0;
    m_pa_x_d      = m_pa_x_q;
    m_pa_y_d      = m_pa_y_q;
    m_pab_x_d     = m_pab_x_q;
    m_pab_y_d     = m_pab_y_q;
    rx_vld        = (rx_state_q == RX_PA) ? i_Pa_valid : i_Pab_valid;
    rx_bx         = (rx_state_q == RX_PA) ? i_Pax : i_Pabx;
    rx_by         = (rx_state_q == RX_PA) ? i_Pay : i_Paby;
    case (rx_state_q)
      RX_IDLE: begin
        // Pab has priority; a colliding Pa frame is dropped and flagged.
        if (i_Pab_valid) begin
          rx_state_d = RX_PAB;
          rx_x_d     = {{(MAX_BITS-1){1'b0}}, i_Pabx};
          rx_y_d     = {{(MAX_BITS-1){1'b0}}, i_Paby};
          rx_rem_d   = last_idx(mode_q);
          m_err_d    = i_Pa_valid;
        end else if (i_Pa_valid) begin
          rx_state_d = RX_PA;
          rx_x_d     = {{(MAX_BITS-1){1'b0}}, i_Pax};
          rx_y_d     = {{(MAX_BITS-1){1'b0}}, i_Pay};
          rx_rem_d   = last_idx(mode_q);
        end
      end
      RX_PA, RX_PAB: begin
        if (!rx_vld) begin
          m_err_d    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_x_d = {rx_x_q[MAX_BITS-2:0], rx_bx};
          rx_y_d = {rx_y_q[MAX_BITS-2:0], rx_by};
          if (rx_rem_q == CNT_W'(1)) begin
            rx_state_d = RX_IDLE;
            if (rx_state_q == RX_PA) begin
              m_pa_valid_d = 1'b1;
              m_pa_x_d     = rx_x_d;
              m_pa_y_d     = rx_y_d;
            end else begin
              m_pab_valid_d = 1'b1;
              m_pab_x_d     = rx_x_d;
              m_pab_y_d     = rx_y_d;
            end
          end else begin
            rx_rem_d = rx_rem_q - CNT_W'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_IDLE;
      mode_q        <= 2'd0;
      tx_cnt_q      <= '0;
      rx_rem_q      <= '0;
      init_q        <= 1'b0;
      m_pa_valid_q  <= 1'b0;
      m_pab_valid_q <= 1'b0;
      m_err_q       <= 1'b0;
      m_pa_x_q      <= '0;
      m_pa_y_q      <= '0;
      m_pab_x_q     <= '0;
      m_pab_y_q     <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      mode_q        <= mode_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_rem_q      <= rx_rem_d;
      init_q        <= init_d;
      m_pa_valid_q  <= m_pa_valid_d;
      m_pab_valid_q <= m_pab_valid_d;
      m_err_q       <= m_err_d;
      m_pa_x_q      <= m_pa_x_d;
      m_pa_y_q      <= m_pa_y_d;
      m_pab_x_q     <= m_pab_x_d;
      m_pab_y_q     <= m_pab_y_d;
    end
  end

  // Shift registers are only meaningful while their FSM state is active.
  always_ff @(posedge clk) begin
    sh_p_q     <= sh_p_d;
    sh_ax_q    <= sh_ax_d;
    sh_ay_q    <= sh_ay_d;
    sh_prime_q <= sh_prime_d;
    sh_pbx_q   <= sh_pbx_d;
    sh_pby_q   <= sh_pby_d;
    rx_x_q     <= rx_x_d;
    rx_y_q     <= rx_y_d;
  end

  assign m_pa_valid  = m_pa_valid_q;
  assign m_pab_valid = m_pab_valid_q;
  assign m_err       = m_err_q;
  assign m_pa_x      = m_pa_x_q;
  assign m_pa_y      = m_pa_y_q;
  assign m_pab_x     = m_pab_x_q;
  assign m_pab_y     = m_pab_y_q;

endmodule
